// File: rtl/lzy_mod_counter.sv
// rtl/lzy_mod_counter.sv - presettable modulo-N up/down counter with 161-style cascade controls
// Synchronous MR/PE/CEP/CET control set, clamped load, registered wrap pulse.
module lzy_mod_counter #(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 16,
    parameter int RESET_VAL = 0
) (
    input  logic             Clk,
    input  logic             MR,
    input  logic             CEP,
    input  logic             CET,
    input  logic             PE,
    input  logic             UD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             C,
    output logic             WRAP
);

    generate
        if (WIDTH < 1 || MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH) ||
            RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_param_err
            $error("lzy_mod_counter: illegal WIDTH/MODULUS/RESET_VAL combination");
        end
    endgenerate

    localparam logic [WIDTH-1:0] L_TOP = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] L_RST = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;

    logic             w_at_top;
    logic             w_at_zero;
    logic             w_term;
    logic             w_count;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_load;

    assign w_at_top  = (r_q == L_TOP);
    assign w_at_zero = (r_q == '0);
    // The terminal state in the current direction is also the state a count edge wraps from.
    assign w_term    = UD ? w_at_top : w_at_zero;
    assign w_count   = CEP & CET;
    assign w_load    = (D > L_TOP) ? L_TOP : D;

    always_comb begin
        w_step = r_q;
        if (UD) begin
            w_step = w_at_top ? '0 : r_q + WIDTH'(1);
        end else begin
            w_step = w_at_zero ? L_TOP : r_q - WIDTH'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (MR) begin
            r_q    <= L_RST;
            r_wrap <= 1'b0;
        end else if (!PE) begin
            r_q    <= w_load;
            r_wrap <= 1'b0;
        end else if (w_count) begin
            r_q    <= w_step;
            r_wrap <= w_term;
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign Q    = r_q;
    assign C    = CET & w_term;
    assign WRAP = r_wrap;

endmodule

// File: tb/tb_lzy_mod_counter.sv
// tb/tb_lzy_mod_counter.sv - directed self-checking bench for lzy_mod_counter
// Covers mod-10 counting, clamp, gating, priority, a mod-16 instance and a two-digit cascade.
module tb_lzy_mod_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Single-counter, MODULUS=10
    logic       mr, cep, cet, pe, ud;
    logic [3:0] d;
    logic [3:0] q;
    logic       c, wrap;

    lzy_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_dut (
        .Clk(clk), .MR(mr), .CEP(cep), .CET(cet), .PE(pe), .UD(ud),
        .D(d), .Q(q), .C(c), .WRAP(wrap)
    );

    // Full-range instance, MODULUS=2^WIDTH
    logic       mr16, pe16, ud16;
    logic [3:0] d16;
    logic [3:0] q16;
    logic       c16, wrap16;

    lzy_mod_counter #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0)) u_dut16 (
        .Clk(clk), .MR(mr16), .CEP(1'b1), .CET(1'b1), .PE(pe16), .UD(ud16),
        .D(d16), .Q(q16), .C(c16), .WRAP(wrap16)
    );

    // Two-digit decimal cascade
    logic       cas_mr;
    logic [3:0] cq0, cq1;
    logic       cc0, cc1, cw0, cw1;

    lzy_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_cas0 (
        .Clk(clk), .MR(cas_mr), .CEP(1'b1), .CET(1'b1), .PE(1'b1), .UD(1'b1),
        .D(4'd0), .Q(cq0), .C(cc0), .WRAP(cw0)
    );

    lzy_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_cas1 (
        .Clk(clk), .MR(cas_mr), .CEP(1'b1), .CET(cc0), .PE(1'b1), .UD(1'b1),
        .D(4'd0), .Q(cq1), .C(cc1), .WRAP(cw1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int up_q[12]   = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int up_w[12]   = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    int dn_q[3]    = '{9, 8, 7};
    int dn_w[3]    = '{1, 0, 0};
    int wrap1_seen;

    initial begin
        mr = 1'b1; cep = 1'b0; cet = 1'b0; pe = 1'b1; ud = 1'b1; d = 4'd0;
        mr16 = 1'b1; pe16 = 1'b1; ud16 = 1'b1; d16 = 4'd0;
        cas_mr = 1'b1;

        // Reset state
        tick();
        check("rst_q", 32'(q), 32'd0);
        check("rst_wrap", 32'(wrap), 32'd0);
        check("rst_c_cet0", 32'(c), 32'd0);

        // Up count through the modulus
        mr = 1'b0; cep = 1'b1; cet = 1'b1; pe = 1'b1; ud = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check($sformatf("up_q[%0d]", i), 32'(q), 32'(up_q[i]));
            check($sformatf("up_wrap[%0d]", i), 32'(wrap), 32'(up_w[i]));
            check($sformatf("up_c[%0d]", i), 32'(c), (up_q[i] == 9) ? 32'd1 : 32'd0);
        end

        // Down count from 0
        mr = 1'b1;
        tick();
        mr = 1'b0; ud = 1'b0;
        #1;
        check("dn_c_at0", 32'(c), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("dn_q[%0d]", i), 32'(q), 32'(dn_q[i]));
            check($sformatf("dn_wrap[%0d]", i), 32'(wrap), 32'(dn_w[i]));
            check($sformatf("dn_c[%0d]", i), 32'(c), 32'd0);
        end

        // Load clamp, enables off
        cep = 1'b0; cet = 1'b0; pe = 1'b0; d = 4'hC;
        tick();
        check("clamp_q", 32'(q), 32'd9);
        check("clamp_wrap", 32'(wrap), 32'd0);
        d = 4'd3;
        tick();
        check("load3_q", 32'(q), 32'd3);

        // Enable gating at the terminal state
        d = 4'd9;
        tick();
        pe = 1'b1; ud = 1'b1; cep = 1'b0; cet = 1'b1;
        tick();
        check("gate_q_hold", 32'(q), 32'd9);
        check("gate_c_cet1", 32'(c), 32'd1);
        cet = 1'b0;
        #1;
        check("gate_c_cet0", 32'(c), 32'd0);
        cep = 1'b1;
        tick();
        check("gate_q_hold2", 32'(q), 32'd9);
        check("gate_wrap", 32'(wrap), 32'd0);

        // Load after a wrap clears WRAP
        cet = 1'b1;
        tick();
        check("wrap_again", 32'(wrap), 32'd1);
        pe = 1'b0; d = 4'd5;
        tick();
        check("pri_load5", 32'(q), 32'd5);
        check("load_clr_wrap", 32'(wrap), 32'd0);

        // MR beats load and count
        mr = 1'b1; pe = 1'b0; d = 4'd7; cep = 1'b1; cet = 1'b1;
        tick();
        check("pri_mr_q", 32'(q), 32'd0);
        check("pri_mr_wrap", 32'(wrap), 32'd0);
        check("pri_mr_c", 32'(c), 32'd0);
        mr = 1'b0;
        tick();
        check("pri_load7", 32'(q), 32'd7);

        // Natural-overflow modulus
        mr16 = 1'b0; pe16 = 1'b0; d16 = 4'd15;
        tick();
        check("m16_load15", 32'(q16), 32'd15);
        check("m16_c", 32'(c16), 32'd1);
        pe16 = 1'b1;
        tick();
        check("m16_up_q", 32'(q16), 32'd0);
        check("m16_up_wrap", 32'(wrap16), 32'd1);
        ud16 = 1'b0;
        tick();
        check("m16_dn_q", 32'(q16), 32'd15);
        check("m16_dn_wrap", 32'(wrap16), 32'd1);
        tick();
        check("m16_dn2_q", 32'(q16), 32'd14);
        check("m16_dn2_wrap", 32'(wrap16), 32'd0);

        // Two-digit cascade, 100 edges
        tick();
        cas_mr = 1'b0;
        check("cas_rst", 32'(cq1 * 10 + cq0), 32'd0);
        wrap1_seen = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            check($sformatf("cas_val[%0d]", i), 32'(cq1 * 10 + cq0), 32'(i % 100));
            if (cw1) wrap1_seen++;
        end
        check("cas_wrap1_count", 32'(wrap1_seen), 32'd1);
        check("cas_wrap1_last", 32'(cw1), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lzy_mod_counter.md
Name: lzy_mod_counter

Overview:
Parametrised successor to the team's 4-bit 74HC161-style counter: a synchronous presettable up/down counter with a programmable modulus.
- Keeps the 161 control set: CEP/CET enables, active-low parallel load PE, terminal-count output C.
- Adds generic width, modulo-N wrap, count direction, load clamping and a registered wrap pulse.
- Used as a cascadable timing and sequencing element (BCD digits, dividers) in the lab designs.

Parameters:
WIDTH, 4, counter/data width in bits (>=1).
MODULUS, 16, count range is 0..MODULUS-1. Legal range 2..2^WIDTH; out of range is an elaboration error.
RESET_VAL, 0, value loaded by MR. Must be < MODULUS.

Ports:
Clk  input  1  single clock; all state changes on rising edge.
MR  input  1  reset, synchronous, active-high.
CEP  input  1  count enable (parallel).
CET  input  1  count enable (trickle). Also gates C.
PE  input  1  parallel load, active-low, synchronous.
UD  input  1  direction: 1 = up, 0 = down.
D  input  WIDTH  parallel load data.
Q  output  WIDTH  counter state, registered.
C  output  1  terminal count, combinational from Q, UD and CET.
WRAP  output  1  registered one-cycle pulse following a counting wrap.

Behaviour:
- Reset: on a rising Clk edge with MR=1, Q<=RESET_VAL and WRAP<=0. MR has absolute priority over every other input. No asynchronous path exists.
- Priority per edge is MR > load (PE=0) > count (CEP&CET) > hold.
- Load (MR=0, PE=0):
  - Q<=D if D<MODULUS; otherwise Q<=MODULUS-1 (clamp).
  - Load ignores CEP, CET and UD.
  - WRAP<=0.
- Count (MR=0, PE=1, CEP=1, CET=1):
  - Up: Q<=Q+1, except Q==MODULUS-1 gives Q<=0.
  - Down: Q<=Q-1, except Q==0 gives Q<=MODULUS-1.
  - WRAP<=1 only on the edge where a wrap transition occurs; otherwise WRAP<=0.
- Hold (MR=0, PE=1, CEP&CET=0): Q unchanged, WRAP<=0.
- Terminal count: C = CET & (UD ? Q==MODULUS-1 : Q==0).
  - C does not depend on CEP, matching 74HC161 cascade semantics.
  - Cascade rule: C of stage n drives CET of stage n+1.
- Latency:
  - Q updates one cycle after the qualifying edge.
  - C follows Q and UD combinationally, with zero cycles of latency.
  - WRAP is high for exactly the cycle after the wrap edge.
- Changing UD mid-count takes effect on the next edge. No glitch or state is lost; C re-evaluates immediately.
- Out-of-range state: Q>=MODULUS is unreachable by construction.
- Arithmetic:
  - Comparisons and increments use WIDTH bits.
  - When MODULUS==2^WIDTH, wrap is natural overflow, and the result must be identical to the explicit compare.
- Reset mid-operation: MR asserted during a count or load edge overrides it. The next cycle shows Q=RESET_VAL, WRAP=0 and C recomputed.

Test Plan:
1. WIDTH=4, MODULUS=10. Assert MR for 1 cycle, then hold CEP=CET=PE=UD=1 for 12 edges. Required: Q = 0,1,...,9,0,1,2. C=1 only while Q=9. WRAP=1 only in the cycle where Q first reads 0 after 9.
2. UD=0 from Q=0 with counting enabled. Required: Q = 9,8,7. C=1 while Q=0. WRAP pulses in the cycle Q reads 9.
3. Load clamp: PE=0 with D=4'hC. Required: Q=9 next cycle, WRAP=0, regardless of CEP=CET=0. Then load D=3, required: Q=3.
4. Enable gating: CEP=0, CET=1 at Q=9 with UD=1. Required: Q holds at 9 and C=1. Then CET=0: C=0 and Q holds.
5. Priority: at Q=5, drive MR=1 and PE=0 with D=7 and count enabled on the same edge. Required: Q=RESET_VAL=0 and WRAP=0. Next edge with MR=0 and PE=0: Q=7.
6. Cascade with two instances, MODULUS=10: stage0 C drives stage1 CET, CEP tied high on both. Run 100 edges from reset. Required: {Q1,Q0} steps 00..99, then 00. Stage1 WRAP pulses exactly once.
